// File: rtl/fifo_sync_flags_pkg.sv
// Shared constants and types for the parametrised synchronous FIFO.
// Mode selectors for the FWFT parameter and the registered status-flag bundle.
package fifo_sync_flags_pkg;

  localparam int unsigned FWFT_OFF = 0;
  localparam int unsigned FWFT_ON  = 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RESET = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

endpackage

// File: rtl/dpram_param.sv
// Simple dual-port RAM: one write port and one registered, enabled read port.
// The read register clears on reset/clr so the FIFO output starts at zero.
module dpram_param #(
  parameter int unsigned DWIDTH = 40,
  parameter int unsigned AWIDTH = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

`ifdef hard_mem
  dual_port_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_hard_ram (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );
`else
  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read-first: a same-address write in the same cycle returns the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end
`endif

endmodule

// File: rtl/fifo_sync_flags.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, sticky
// error flags and an optional first-word-fall-through output stage.
module fifo_sync_flags
  import fifo_sync_flags_pkg::*;
#(
  parameter int unsigned DW         = 40,
  parameter int unsigned AW         = 9,
  parameter int unsigned AFULL_THR  = 480,
  parameter int unsigned AEMPTY_THR = 32,
  parameter int unsigned FWFT       = FWFT_OFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          we,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned Depth   = 1 << AW;
  localparam logic [AW:0] DepthC  = (AW+1)'(Depth);
  localparam logic [AW:0] AfullC  = (AW+1)'(AFULL_THR);
  localparam logic [AW:0] AemptyC = (AW+1)'(AEMPTY_THR);

  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  fifo_flags_t   flags_q, flags_d;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;
  logic          rd_ok, wr_ok, ram_re, fetch, empty_next;
  logic [DW-1:0] ram_rdata;

  assign rd_ok = re & ~flags_q.empty;
  assign wr_ok = we & (~flags_q.full | rd_ok);

  // In FWFT mode the RAM is read by the prefetcher, not directly by the reader.
  assign ram_re = (FWFT == FWFT_ON) ? fetch : rd_ok;

  always_comb begin
    count_d     = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    wp_d        = wp_q + AW'(wr_ok);
    rp_d        = rp_q + AW'(ram_re);
    overflow_d  = overflow_q | (we & ~wr_ok);
    underflow_d = underflow_q | (re & flags_q.empty);
    flags_d.full         = (count_d == DepthC);
    flags_d.empty        = empty_next;
    flags_d.almost_full  = (count_d >= AfullC);
    flags_d.almost_empty = (count_d <= AemptyC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      flags_q     <= FLAGS_RESET;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clr) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      flags_q     <= FLAGS_RESET;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      flags_q     <= flags_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  dpram_param #(
    .DWIDTH (DW),
    .AWIDTH (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .we    (wr_ok & ~clr),
    .waddr (wp_q),
    .wdata (din),
    .re    (ram_re & ~clr),
    .raddr (rp_q),
    .rdata (ram_rdata)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    logic          valid_q, pend_q, pend_move;
    logic [AW:0]   mcnt_q;
    logic [DW-1:0] out_q;

    // pend_q: a RAM read was issued and its word sits on ram_rdata.
    assign pend_move  = pend_q & (~valid_q | rd_ok);
    assign fetch      = (mcnt_q != '0) & (~pend_q | pend_move);
    assign empty_next = ~(pend_move | (valid_q & ~rd_ok));
    assign dout       = out_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= 1'b0;
        pend_q  <= 1'b0;
        mcnt_q  <= '0;
        out_q   <= '0;
      end else if (clr) begin
        valid_q <= 1'b0;
        pend_q  <= 1'b0;
        mcnt_q  <= '0;
        out_q   <= '0;
      end else begin
        valid_q <= pend_move | (valid_q & ~rd_ok);
        pend_q  <= fetch | (pend_q & ~pend_move);
        mcnt_q  <= mcnt_q + (AW+1)'(wr_ok) - (AW+1)'(fetch);
        if (pend_move) begin
          out_q <= ram_rdata;
        end
      end
    end
  end else begin : g_std
    assign fetch      = 1'b0;
    assign empty_next = (count_d == '0);
    assign dout       = ram_rdata;
  end

  assign count        = count_q;
  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench: standard-mode FIFO (512x40) against a queue model, plus
// a small FWFT instance checked for latency and one-word-per-cycle streaming.
module tb_fifo_sync_flags;

  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        s_clr = 1'b0, s_we = 1'b0, s_re = 1'b0;
  logic [39:0] s_din = '0, s_dout;
  logic        s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
  logic [9:0]  s_count;

  logic        f_clr = 1'b0, f_we = 1'b0, f_re = 1'b0;
  logic [39:0] f_din = '0, f_dout;
  logic        f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [4:0]  f_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [39:0] q[$];
  int          m_cnt = 0;
  logic        m_ovf = 1'b0, m_unf = 1'b0;
  logic [39:0] m_dout = '0;

  fifo_sync_flags #(
    .DW (40), .AW (9), .AFULL_THR (480), .AEMPTY_THR (32), .FWFT (0)
  ) u_std (
    .clk (clk), .rst (rst), .clr (s_clr), .din (s_din), .we (s_we), .re (s_re),
    .dout (s_dout), .full (s_full), .empty (s_empty), .almost_full (s_afull),
    .almost_empty (s_aempty), .count (s_count), .overflow (s_ovf), .underflow (s_unf)
  );

  fifo_sync_flags #(
    .DW (40), .AW (4), .AFULL_THR (12), .AEMPTY_THR (2), .FWFT (1)
  ) u_fwft (
    .clk (clk), .rst (rst), .clr (f_clr), .din (f_din), .we (f_we), .re (f_re),
    .dout (f_dout), .full (f_full), .empty (f_empty), .almost_full (f_afull),
    .almost_empty (f_aempty), .count (f_count), .overflow (f_ovf), .underflow (f_unf)
  );

  // One clock of standard-mode traffic; model updated before the edge, DUT checked after.
  task automatic step(input logic clr, input logic we, input logic [39:0] d, input logic re);
    logic       rd_ok, wr_ok;
    logic [5:0] exp_fl, got_fl;
    s_clr = clr; s_we = we; s_din = d; s_re = re;
    if (clr) begin
      q.delete(); m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    end else begin
      rd_ok = re && (m_cnt != 0);
      wr_ok = we && ((m_cnt != DEPTH) || rd_ok);
      if (re && m_cnt == 0) m_unf = 1'b1;
      if (we && !wr_ok) m_ovf = 1'b1;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
      m_cnt = m_cnt + int'(wr_ok) - int'(rd_ok);
    end
    @(posedge clk); #1;
    exp_fl = {m_cnt == DEPTH, m_cnt == 0, m_cnt >= 480, m_cnt <= 32, m_ovf, m_unf};
    got_fl = {s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf};
    chk_cnt++;
    if (s_dout !== m_dout) $display("FAIL std_dout: got %0h want %0h", s_dout, m_dout);
    else pass_cnt++;
    chk_cnt++;
    if (s_count !== 10'(m_cnt)) $display("FAIL std_count: got %0d want %0d", s_count, m_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (got_fl !== exp_fl)
      $display("FAIL std_flags(f,e,af,ae,ov,un): got %b want %b cnt=%0d", got_fl, exp_fl, m_cnt);
    else pass_cnt++;
    s_clr = 1'b0; s_we = 1'b0; s_re = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    chk_cnt++;
    if ({s_count, s_empty, s_full, s_aempty, s_afull, s_ovf, s_unf} !== {10'd0, 6'b101000})
      $display("FAIL reset_std: got cnt=%0d e=%b f=%b ae=%b af=%b", s_count, s_empty,
               s_full, s_aempty, s_afull);
    else pass_cnt++;
    chk_cnt++;
    if (s_dout !== 40'd0) $display("FAIL reset_dout: got %0h want 0", s_dout);
    else pass_cnt++;
    chk_cnt++;
    if ({f_count, f_empty, f_full, f_ovf, f_unf, f_dout} !== {5'd0, 4'b1000, 40'd0})
      $display("FAIL reset_fwft: got cnt=%0d e=%b dout=%0h", f_count, f_empty, f_dout);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 40'(i), 1'b0);
    step(1'b0, 1'b1, 40'd999, 1'b0);
    chk_cnt++;
    if ({s_full, s_ovf, s_count} !== {2'b11, 10'd512})
      $display("FAIL overflow_full: got f=%b ov=%b cnt=%0d want 1 1 512", s_full, s_ovf, s_count);
    else pass_cnt++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk_cnt++;
    if ({s_dout, s_unf, s_empty} !== {40'd511, 2'b11})
      $display("FAIL underflow_hold: got dout=%0d un=%b e=%b want 511 1 1", s_dout, s_unf, s_empty);
    else pass_cnt++;
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 40'(2000 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 40'(1000 + i), 1'b1);
    chk_cnt++;
    if ({s_full, s_count} !== {1'b1, 10'd512})
      $display("FAIL full_rw: got f=%b cnt=%0d want 1 512", s_full, s_count);
    else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk_cnt++;
    if (s_dout !== 40'd1009) $display("FAIL full_rw_tail: got %0d want 1009", s_dout);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 1500; i++) step(1'b0, 1'b1, 40'(3000 + i), m_cnt >= 3);
    while (m_cnt > 0) step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 40'(5000 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_fwft();
    logic [39:0] fq[$];
    logic [39:0] exp;
    int pushed = 0, popped = 0, first = -1, last = -1;
    f_we = 1'b1; f_din = 40'hA5;
    @(posedge clk); #1;
    f_we = 1'b0;
    chk_cnt++;
    if ({f_empty, f_count} !== {1'b1, 5'd1})
      $display("FAIL fwft_lat0: got e=%b cnt=%0d want 1 1", f_empty, f_count);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if (f_empty !== 1'b1) $display("FAIL fwft_lat1: got e=%b want 1", f_empty);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if ({f_empty, f_dout} !== {1'b0, 40'hA5})
      $display("FAIL fwft_lat2: got e=%b dout=%0h want 0 a5", f_empty, f_dout);
    else pass_cnt++;
    f_re = 1'b1;
    @(posedge clk); #1;
    f_re = 1'b0;
    chk_cnt++;
    if ({f_empty, f_count} !== {1'b1, 5'd0})
      $display("FAIL fwft_pop: got e=%b cnt=%0d want 1 0", f_empty, f_count);
    else pass_cnt++;
    for (int cyc = 0; cyc < 300 && popped < 100; cyc++) begin
      f_we = (pushed < 100); f_din = 40'(500 + pushed); f_re = 1'b1;
      if (!f_empty) begin
        if (fq.size() == 0) begin
          chk_cnt++;
          $display("FAIL fwft_spurious: dout=%0h with nothing outstanding", f_dout);
        end else begin
          exp = fq.pop_front();
          chk_cnt++;
          if (f_dout !== exp) $display("FAIL fwft_data: got %0d want %0d", f_dout, exp);
          else pass_cnt++;
        end
        popped++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (f_we) begin
        fq.push_back(f_din);
        pushed++;
      end
      @(posedge clk); #1;
      chk_cnt++;
      if (f_count !== 5'(pushed - popped))
        $display("FAIL fwft_count: got %0d want %0d", f_count, pushed - popped);
      else pass_cnt++;
    end
    f_we = 1'b0; f_re = 1'b0;
    chk_cnt++;
    if (popped != 100 || last - first != 99)
      $display("FAIL fwft_stream: got %0d pops over %0d cycles want 100 over 100", popped,
               last - first + 1);
    else pass_cnt++;
    chk_cnt++;
    if ({f_empty, f_unf, f_aempty} !== 3'b111)
      $display("FAIL fwft_end_flags: got e=%b un=%b ae=%b want 111", f_empty, f_unf, f_aempty);
    else pass_cnt++;
  endtask

  task automatic test_clr();
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 40'(7000 + i), 1'b0);
    step(1'b1, 1'b1, 40'd77, 1'b1);
    chk_cnt++;
    if ({s_count, s_empty, s_ovf, s_unf} !== {10'd0, 3'b100})
      $display("FAIL clr: got cnt=%0d e=%b ov=%b un=%b", s_count, s_empty, s_ovf, s_unf);
    else pass_cnt++;
    step(1'b0, 1'b1, 40'h55, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk_cnt++;
    if (s_dout !== 40'h55) $display("FAIL clr_newdata: got %0h want 55", s_dout);
    else pass_cnt++;
  endtask

  task automatic test_async_rst();
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 40'(8000 + i), 1'b0);
    #3 rst = 1'b0;
    #1;
    q.delete(); m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    chk_cnt++;
    if ({s_count, s_empty, s_ovf, s_unf, s_dout} !== {10'd0, 3'b100, 40'd0})
      $display("FAIL async_rst: got cnt=%0d e=%b ov=%b un=%b dout=%0h", s_count, s_empty,
               s_ovf, s_unf, s_dout);
    else pass_cnt++;
    chk_cnt++;
    if ({f_count, f_empty, f_unf} !== {5'd0, 2'b10})
      $display("FAIL async_rst_fwft: got cnt=%0d e=%b un=%b", f_count, f_empty, f_unf);
    else pass_cnt++;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 1'b1, 40'h66, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk_cnt++;
    if ({s_dout, s_empty} !== {40'h66, 1'b1})
      $display("FAIL rst_newdata: got dout=%0h e=%b want 66 1", s_dout, s_empty);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_wrap();
    test_fwft();
    test_clr();
    test_async_rst();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
